// File: rtl/imem_loader.sv
// imem_loader
//   Boot-time program loader in front of the fetch stage's instruction memory.
//   It takes a length-prefixed byte stream (LEN_LO, LEN_HI, then L payload
//   bytes) over a valid/ready handshake. Each payload byte is written to
//   consecutive instruction-memory addresses starting at 0. The pipeline is
//   held idle until the whole image has been written.
//
// Ports
//   i_clk          processor clock, all state changes on the rising edge
//   i_reset        asynchronous active-high reset
//   i_start        single-cycle pulse, starts a load from IDLE, RUN or ERROR
//   i_in_valid     stream byte valid
//   i_in_data      stream byte
//   i_in_last      marks the final byte of the stream
//   o_in_ready     loader can accept a byte
//   o_wr_en        instruction-memory write strobe (one cycle per byte)
//   o_wr_addr      write byte address
//   o_wr_data      write byte
//   o_byte_count   payload bytes written so far in the current load
//   o_proc_run     pipeline may fetch/advance
//   o_load_error   sticky error flag for the current load
module imem_loader #(
  parameter int ADDR_W    = 10,
  parameter int MAX_BYTES = 1024
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_in_valid,
  input  logic [7:0]        i_in_data,
  input  logic              i_in_last,
  output logic              o_in_ready,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [7:0]        o_wr_data,
  output logic [ADDR_W:0]   o_byte_count,
  output logic              o_proc_run,
  output logic              o_load_error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_LOAD,
    S_RUN,
    S_ERROR
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_in_ready;
  logic                r_wr_en;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [7:0]          r_wr_data;
  logic [ADDR_W:0]     r_count;
  logic                r_proc_run;
  logic                r_load_error;
  logic [7:0]          r_len_lo;
  logic [15:0]         r_len;

  logic                w_accept;
  logic [15:0]         w_len;
  logic                w_last_payload;
  logic                w_final_accept;
  logic                w_payload_accept;

  // r_in_ready always equals the ready decode of r_state, so it doubles as
  // the handshake qualifier.
  assign w_accept         = i_in_valid && r_in_ready;
  assign w_len            = {i_in_data, r_len_lo};
  assign w_last_payload   = (32'(r_count) + 32'd1) == 32'(r_len);
  assign w_payload_accept = (r_state == S_LOAD) && w_accept;
  assign w_final_accept   = w_payload_accept && w_last_payload;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_RUN, S_ERROR: begin
        if (i_start) w_next = S_LEN_LO;
      end
      S_LEN_LO: begin
        if (w_accept) w_next = i_in_last ? S_ERROR : S_LEN_HI;
      end
      S_LEN_HI: begin
        // A zero-length image may legally end on LEN_HI, so it is
        // checked before the in_last header error.
        if (w_accept) begin
          if ({16'd0, w_len} > MAX_BYTES) w_next = S_ERROR;
          else if (w_len == 16'd0)        w_next = S_RUN;
          else if (i_in_last)             w_next = S_ERROR;
          else                            w_next = S_LOAD;
        end
      end
      S_LOAD: begin
        if (w_accept) begin
          if (w_last_payload) w_next = S_RUN;
          else if (i_in_last) w_next = S_ERROR;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_in_ready   <= 1'b0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= 8'd0;
      r_count      <= '0;
      r_proc_run   <= 1'b0;
      r_load_error <= 1'b0;
      r_len_lo     <= 8'd0;
      r_len        <= 16'd0;
    end else begin
      r_state    <= w_next;
      r_in_ready <= (w_next == S_LEN_LO) || (w_next == S_LEN_HI) || (w_next == S_LOAD);
      // Entering RUN from LOAD holds proc_run low one extra cycle so the
      // final write lands before the first fetch.
      r_proc_run <= (w_next == S_RUN) && !w_final_accept;
      r_wr_en    <= w_payload_accept;

      if (w_payload_accept) begin
        r_wr_addr <= r_count[ADDR_W-1:0];
        r_wr_data <= i_in_data;
        r_count   <= r_count + 1'b1;
      end

      if ((r_state == S_LEN_LO) && w_accept) r_len_lo <= i_in_data;
      if ((r_state == S_LEN_HI) && w_accept) r_len    <= w_len;

      if ((w_next == S_LEN_LO) && (r_state != S_LEN_LO)) begin
        r_count      <= '0;
        r_load_error <= 1'b0;
      end else if (w_next == S_ERROR) begin
        r_load_error <= 1'b1;
      end
    end
  end

  assign o_in_ready   = r_in_ready;
  assign o_wr_en      = r_wr_en;
  assign o_wr_addr    = r_wr_addr;
  assign o_wr_data    = r_wr_data;
  assign o_byte_count = r_count;
  assign o_proc_run   = r_proc_run;
  assign o_load_error = r_load_error;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader
//   Self-checking bench for imem_loader. A stream-level model (byte position
//   in the stream, image length, loading/running/error flags) predicts every
//   output each cycle; directed scenarios add literal expectations on the
//   write sequence and proc_run timing, followed by randomized images.
module tb_imem_loader;

  localparam int ADDR_W    = 10;
  localparam int MAX_BYTES = 1024;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              inValid = 1'b0;
  logic [7:0]        inData = 8'd0;
  logic              inLast = 1'b0;
  logic              inReady;
  logic              wrEn;
  logic [ADDR_W-1:0] wrAddr;
  logic [7:0]        wrData;
  logic [ADDR_W:0]   byteCount;
  logic              procRun;
  logic              loadError;

  imem_loader #(.ADDR_W(ADDR_W), .MAX_BYTES(MAX_BYTES)) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_start      (start),
    .i_in_valid   (inValid),
    .i_in_data    (inData),
    .i_in_last    (inLast),
    .o_in_ready   (inReady),
    .o_wr_en      (wrEn),
    .o_wr_addr    (wrAddr),
    .o_wr_data    (wrData),
    .o_byte_count (byteCount),
    .o_proc_run   (procRun),
    .o_load_error (loadError)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Stream-level model state
  bit mLoading, mRunning, mPending, mErr, mWr;
  int mPos, mLen, mLo, mCnt, mAddr, mData;

  // Writes seen on the DUT write port, encoded addr*256+data
  int wlog[$];

  task automatic checkOne(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic modelReset();
    mLoading = 0; mRunning = 0; mPending = 0; mErr = 0; mWr = 0;
    mPos = 0; mLen = 0; mLo = 0; mCnt = 0; mAddr = 0; mData = 0;
  endtask

  task automatic modelFail();
    mLoading = 0;
    mErr     = 1;
  endtask

  // One rising edge of the model, using the inputs held during that cycle
  task automatic modelStep();
    mWr = 0;
    if (mPending) begin
      mRunning = 1;
      mPending = 0;
    end
    if (start && !mLoading) begin
      mLoading = 1; mPos = 0; mCnt = 0; mErr = 0; mRunning = 0; mPending = 0;
    end else if (inValid && mLoading) begin
      if (mPos == 0) begin
        mLo = int'(inData);
        if (inLast) modelFail();
      end else if (mPos == 1) begin
        mLen = int'(inData) * 256 + mLo;
        if (mLen > MAX_BYTES) modelFail();
        else if (mLen == 0) begin
          mLoading = 0;
          mRunning = 1;
        end else if (inLast) modelFail();
      end else begin
        mWr   = 1;
        mAddr = mPos - 2;
        mData = int'(inData);
        mCnt++;
        if (mPos - 2 == mLen - 1) begin
          mLoading = 0;
          mPending = 1;
        end else if (inLast) modelFail();
      end
      mPos++;
    end
  endtask

  task automatic checkOutput();
    checkOne("in_ready",   int'(inReady),   int'(mLoading));
    checkOne("wr_en",      int'(wrEn),      int'(mWr));
    checkOne("wr_addr",    int'(wrAddr),    mAddr);
    checkOne("wr_data",    int'(wrData),    mData);
    checkOne("byte_count", int'(byteCount), mCnt);
    checkOne("proc_run",   int'(procRun),   int'(mRunning));
    checkOne("load_error", int'(loadError), int'(mErr));
    if (wrEn) wlog.push_back(int'(wrAddr) * 256 + int'(wrData));
  endtask

  // Called at a falling edge; drives one cycle and checks at the next falling edge
  task automatic applyStimulus(input bit s, input bit v, input logic [7:0] d, input bit l);
    start = s; inValid = v; inData = d; inLast = l;
    @(posedge clk);
    modelStep();
    @(negedge clk);
    checkOutput();
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, 8'($urandom), 1'b0);
  endtask

  task automatic sendByte(input logic [7:0] d, input bit l, input int gaps);
    idle(gaps);
    applyStimulus(1'b0, 1'b1, d, l);
  endtask

  task automatic checkWrites(input string name, input int exp[$]);
    checkOne({name, "_count"}, wlog.size(), exp.size());
    for (int i = 0; i < exp.size() && i < wlog.size(); i++)
      checkOne(name, wlog[i], exp[i]);
  endtask

  task automatic checkResetValues(input string name);
    checkOne({name, "_in_ready"},   int'(inReady),   0);
    checkOne({name, "_wr_en"},      int'(wrEn),      0);
    checkOne({name, "_wr_addr"},    int'(wrAddr),    0);
    checkOne({name, "_wr_data"},    int'(wrData),    0);
    checkOne({name, "_byte_count"}, int'(byteCount), 0);
    checkOne({name, "_proc_run"},   int'(procRun),   0);
    checkOne({name, "_load_error"}, int'(loadError), 0);
  endtask

  task automatic sendImage4(input int gaps);
    sendByte(8'h04, 1'b0, 0);
    sendByte(8'h00, 1'b0, gaps);
    sendByte(8'h30, 1'b0, gaps);
    sendByte(8'hF2, 1'b0, gaps);
    sendByte(8'h0A, 1'b0, gaps);
    sendByte(8'h00, 1'b1, gaps);
  endtask

  initial begin
    int exp4[$];
    int q[$];
    exp4 = '{32'h030, 32'h1F2, 32'h20A, 32'h300};
    modelReset();

    // Reset state
    repeat (2) @(negedge clk);
    checkResetValues("reset");
    reset = 1'b0;

    // Full load and proc_run timing
    wlog.delete();
    applyStimulus(1'b1, 1'b0, 8'd0, 1'b0);
    sendImage4(0);
    checkOne("full_wr_en_n1", int'(wrEn), 1);
    checkOne("full_run_n1", int'(procRun), 0);
    idle(1);
    checkOne("full_run_n2", int'(procRun), 1);
    checkOne("full_count", int'(byteCount), 4);
    checkWrites("full_writes", exp4);

    // Backpressure: valid pattern 1,0,0,1,...
    wlog.delete();
    applyStimulus(1'b1, 1'b0, 8'd0, 1'b0);
    sendImage4(2);
    idle(2);
    checkOne("gap_run", int'(procRun), 1);
    checkWrites("gap_writes", exp4);

    // Truncated image
    wlog.delete();
    applyStimulus(1'b1, 1'b0, 8'd0, 1'b0);
    sendByte(8'h03, 1'b0, 0);
    sendByte(8'h00, 1'b0, 0);
    sendByte(8'hAA, 1'b0, 0);
    sendByte(8'hBB, 1'b1, 0);
    idle(2);
    checkOne("trunc_err", int'(loadError), 1);
    checkOne("trunc_ready", int'(inReady), 0);
    checkOne("trunc_run", int'(procRun), 0);
    q = '{32'h0AA, 32'h1BB};
    checkWrites("trunc_writes", q);

    // Oversize length, then recovery with a 1-byte image
    wlog.delete();
    applyStimulus(1'b1, 1'b0, 8'd0, 1'b0);
    sendByte(8'h01, 1'b0, 0);
    sendByte(8'h04, 1'b0, 0);
    sendByte(8'h77, 1'b0, 0);
    checkOne("over_err", int'(loadError), 1);
    checkOne("over_writes", wlog.size(), 0);
    applyStimulus(1'b1, 1'b0, 8'd0, 1'b0);
    checkOne("over_err_clr", int'(loadError), 0);
    sendByte(8'h01, 1'b0, 0);
    sendByte(8'h00, 1'b0, 0);
    sendByte(8'h5C, 1'b1, 0);
    idle(1);
    checkOne("over_run", int'(procRun), 1);
    q = '{32'h05C};
    checkWrites("over_reload", q);

    // Empty image
    wlog.delete();
    applyStimulus(1'b1, 1'b0, 8'd0, 1'b0);
    sendByte(8'h00, 1'b0, 0);
    sendByte(8'h00, 1'b1, 0);
    checkOne("empty_run", int'(procRun), 1);
    checkOne("empty_writes", wlog.size(), 0);

    // Reset mid-load after 2 of 4 payload bytes
    applyStimulus(1'b1, 1'b0, 8'd0, 1'b0);
    sendByte(8'h04, 1'b0, 0);
    sendByte(8'h00, 1'b0, 0);
    sendByte(8'h11, 1'b0, 0);
    sendByte(8'h22, 1'b0, 0);
    #2 reset = 1'b1;
    #1 checkResetValues("midreset");
    modelReset();
    @(negedge clk);
    reset = 1'b0;
    wlog.delete();
    applyStimulus(1'b1, 1'b0, 8'd0, 1'b0);
    sendImage4(0);
    idle(1);
    checkOne("midreset_run", int'(procRun), 1);
    checkWrites("midreset_writes", exp4);

    // Randomized images with gaps, stray starts and stray in_last
    for (int it = 0; it < 60; it++) begin
      int len, sendN, sel;
      sel = int'($urandom_range(0, 9));
      if (it == 7)       len = MAX_BYTES;
      else if (sel == 0) len = 0;
      else if (sel == 1) len = MAX_BYTES + 1 + int'($urandom_range(0, 40000));
      else               len = int'($urandom_range(1, 8));
      sendN = (len > MAX_BYTES) ? 3 : len;
      applyStimulus(1'b1, 1'b0, 8'd0, 1'b0);
      sendByte(8'(len), 1'b0, (it == 7) ? 0 : int'($urandom_range(0, 2)));
      sendByte(8'(len >> 8), (len == 0) ? 1'($urandom) : ($urandom_range(0, 15) == 0),
               (it == 7) ? 0 : int'($urandom_range(0, 2)));
      for (int b = 0; b < sendN; b++) begin
        bit l;
        l = (b == sendN - 1) ? 1'($urandom) : ($urandom_range(0, 19) == 0);
        if (it != 7 && $urandom_range(0, 9) == 0)
          applyStimulus(1'b1, 1'b0, 8'd0, 1'b0);
        sendByte(8'($urandom), l, (it == 7) ? 0 : int'($urandom_range(0, 2)));
      end
      idle(int'($urandom_range(1, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
